// File: rtl/uart_cmd_link_if.sv
// rtl/uart_cmd_link_if.sv - command/read handshake bundle between controller and UART link
interface uart_cmd_link_if #(
   parameter int CMD_WIDTH  = 16,
   parameter int READ_WIDTH = 8
);
   logic [CMD_WIDTH-1:0]  cmd_in;
   logic                  cmd_vld;
   logic                  cmd_rdy;
   logic [READ_WIDTH-1:0] read_data;
   logic                  read_vld;
   logic                  parity_err;
   logic                  frame_err;

   modport master (
      output cmd_in, cmd_vld,
      input  cmd_rdy, read_data, read_vld, parity_err, frame_err
   );

   modport slave (
      input  cmd_in, cmd_vld,
      output cmd_rdy, read_data, read_vld, parity_err, frame_err
   );
endinterface

// File: rtl/uart_cmd_link.sv
// rtl/uart_cmd_link.sv - full-duplex UART: multi-byte command TX, multi-byte read word RX
module uart_cmd_link #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int CMD_WIDTH  = 16,
   parameter int READ_WIDTH = 8,
   parameter int PARITY     = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_cmd_link_if.slave   cmd,
   output logic             tx,
   input  logic             rx
);
   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF   = CW'(DIV / 2);
   localparam int TNB = CMD_WIDTH / 8;
   localparam int RNB = READ_WIDTH / 8;
   localparam int TBW = $clog2(TNB + 1);
   localparam int RBW = $clog2(RNB + 1);
   localparam logic [TBW-1:0] T_LAST = TBW'(TNB - 1);
   localparam logic [RBW-1:0] R_LAST = RBW'(RNB - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;

   function automatic logic par_bit(input logic [7:0] b);
      return (PARITY == 2) ? ^b : ~^b;
   endfunction

   state_t                tx_state, tx_next;
   logic [CW-1:0]         tx_cnt;
   logic [2:0]            tx_bit;
   logic [TBW-1:0]        tx_bcnt;
   logic [CMD_WIDTH-1:0]  tx_word;
   logic [7:0]            tx_byte;
   logic                  tx_tick;

   assign tx_byte     = tx_word[CMD_WIDTH-1 -: 8];
   assign tx_tick     = (tx_cnt == DIV_M1);
   assign cmd.cmd_rdy = (tx_state == S_IDLE);

   always_comb begin
      tx_next = tx_state;
      tx      = 1'b1;
      case (tx_state)
         S_IDLE:  if (cmd.cmd_vld) tx_next = S_START;
         S_START: begin
            tx = 1'b0;
            if (tx_tick) tx_next = S_DATA;
         end
         S_DATA: begin
            tx = tx_byte[tx_bit];
            if (tx_tick && tx_bit == 3'd7) tx_next = (PARITY != 0) ? S_PAR : S_STOP;
         end
         S_PAR: begin
            tx = par_bit(tx_byte);
            if (tx_tick) tx_next = S_STOP;
         end
         S_STOP:  if (tx_tick) tx_next = (tx_bcnt == T_LAST) ? S_IDLE : S_START;
         default: tx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_bcnt  <= '0;
         tx_word  <= '0;
      end else begin
         tx_state <= tx_next;
         tx_cnt   <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
         if (tx_state == S_IDLE && cmd.cmd_vld) begin
            tx_word <= cmd.cmd_in;
            tx_bcnt <= '0;
         end
         if (tx_state == S_DATA && tx_tick) tx_bit <= tx_bit + 3'd1;
         // Next byte moves into the MSB slot once the current stop bit ends
         if (tx_state == S_STOP && tx_tick) begin
            tx_word <= tx_word << 8;
            tx_bcnt <= tx_bcnt + 1'b1;
         end
      end
   end

   logic                  rx_s1, rx_s2, rx_prev;
   state_t                rx_state, rx_next;
   logic [CW-1:0]         rx_cnt;
   logic [2:0]            rx_bit;
   logic [RBW-1:0]        rx_bcnt;
   logic [7:0]            rx_byte;
   logic [READ_WIDTH-1:0] rx_word, rx_word_nxt;
   logic                  rx_perr, rx_ferr, rx_tick;

   assign rx_tick     = (rx_cnt == ((rx_state == S_START) ? HALF : DIV_M1));
   assign rx_word_nxt = (rx_word << 8) | READ_WIDTH'(rx_byte);

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:  if (rx_prev && !rx_s2) rx_next = S_START;
         S_START: if (rx_tick) rx_next = rx_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = (PARITY != 0) ? S_PAR : S_STOP;
         S_PAR:   if (rx_tick) rx_next = S_STOP;
         // A low stop bit may be a break; hold off re-arming until the line idles
         S_STOP:  if (rx_tick) rx_next = rx_s2 ? S_IDLE : S_WAIT;
         S_WAIT:  if (rx_s2) rx_next = S_IDLE;
         default: rx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1          <= 1'b1;
         rx_s2          <= 1'b1;
         rx_prev        <= 1'b1;
         rx_state       <= S_IDLE;
         rx_cnt         <= '0;
         rx_bit         <= '0;
         rx_bcnt        <= '0;
         rx_byte        <= '0;
         rx_word        <= '0;
         rx_perr        <= 1'b0;
         rx_ferr        <= 1'b0;
         cmd.read_data  <= '0;
         cmd.read_vld   <= 1'b0;
         cmd.parity_err <= 1'b0;
         cmd.frame_err  <= 1'b0;
      end else begin
         rx_s1        <= rx;
         rx_s2        <= rx_s1;
         rx_prev      <= rx_s2;
         rx_state     <= rx_next;
         rx_cnt       <= (rx_state == S_IDLE || rx_state == S_WAIT || rx_tick) ? '0 : rx_cnt + 1'b1;
         cmd.read_vld <= 1'b0;
         case (rx_state)
            S_DATA: if (rx_tick) begin
               rx_byte <= {rx_s2, rx_byte[7:1]};
               rx_bit  <= rx_bit + 3'd1;
            end
            S_PAR: if (rx_tick && rx_s2 != par_bit(rx_byte)) rx_perr <= 1'b1;
            S_STOP: if (rx_tick) begin
               if (rx_bcnt == R_LAST) begin
                  cmd.read_data  <= rx_word_nxt;
                  cmd.read_vld   <= 1'b1;
                  cmd.parity_err <= rx_perr;
                  cmd.frame_err  <= rx_ferr | ~rx_s2;
                  rx_perr        <= 1'b0;
                  rx_ferr        <= 1'b0;
                  rx_bcnt        <= '0;
               end else begin
                  rx_word <= rx_word_nxt;
                  rx_bcnt <= rx_bcnt + 1'b1;
                  if (!rx_s2) rx_ferr <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_cmd_link.sv
// tb/tb_uart_cmd_link.sv - directed bench for uart_cmd_link (DIV=10, odd parity, 16-bit words)
module tb_uart_cmd_link;
   logic clk = 1'b0;
   logic rst_n;
   logic tx;
   logic rx_drv;
   logic loop_en;
   logic rx_line;

   int total = 0;
   int bad = 0;
   int vld_cnt = 0;
   logic [15:0] got_data;
   logic        got_p, got_f;

   uart_cmd_link_if #(.CMD_WIDTH(16), .READ_WIDTH(16)) bus ();

   uart_cmd_link #(
      .CLK_FREQ(1000000), .BAUD(100000), .CMD_WIDTH(16), .READ_WIDTH(16), .PARITY(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd(bus.slave), .tx(tx), .rx(rx_line)
   );

   assign rx_line = loop_en ? tx : rx_drv;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.read_vld) begin
         vld_cnt  = vld_cnt + 1;
         got_data = bus.read_data;
         got_p    = bus.parity_err;
         got_f    = bus.frame_err;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line order of one frame: bit 0 is the start bit, bit 10 the stop bit
   function automatic logic [10:0] frame(input logic [7:0] b, input logic flip, input logic stop);
      return {stop, (~^b) ^ flip, b, 1'b0};
   endfunction

   task automatic tx_capture(input logic [15:0] w, input bit inject,
                             output logic [21:0] cap, output int low);
      cap = '0;
      low = 0;
      bus.cmd_in  = w;
      bus.cmd_vld = 1'b1;
      @(posedge clk); #1;
      bus.cmd_vld = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (k < 220 && (k % 10) == 5) cap[k/10] = tx;
         if (!bus.cmd_rdy) low++;
         if (inject && k == 50) begin
            bus.cmd_in  = 16'hFFFF;
            bus.cmd_vld = 1'b1;
         end else begin
            bus.cmd_vld = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic drive_frame(input logic [10:0] f);
      for (int i = 0; i < 11; i++) begin
         rx_drv = f[i];
         repeat (10) begin @(posedge clk); #1; end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      logic [21:0] cap;
      int          low;
      int          base;

      rst_n       = 1'b0;
      loop_en     = 1'b0;
      rx_drv      = 1'b1;
      bus.cmd_in  = '0;
      bus.cmd_vld = 1'b0;
      idle(3);
      check("reset_tx",        tx,             1);
      check("reset_cmd_rdy",   bus.cmd_rdy,    1);
      check("reset_read_vld",  bus.read_vld,   0);
      check("reset_read_data", bus.read_data,  0);
      check("reset_parity",    bus.parity_err, 0);
      check("reset_frame",     bus.frame_err,  0);
      rst_n = 1'b1;
      idle(5);

      // Serialise A55A with an ignored mid-frame request
      tx_capture(16'hA55A, 1'b1, cap, low);
      check("t1_byte1_frame", cap[10:0],  frame(8'hA5, 1'b0, 1'b1));
      check("t1_byte2_frame", cap[21:11], frame(8'h5A, 1'b0, 1'b1));
      check("t1_rdy_low",     low,        220);
      check("t1_tx_idle",     tx,         1);
      check("t1_rdy_back",    bus.cmd_rdy, 1);

      // Loopback
      loop_en = 1'b1;
      base = vld_cnt;
      tx_capture(16'hA55A, 1'b0, cap, low);
      check("t2_vld_pulses", vld_cnt - base, 1);
      check("t2_data",       got_data, 16'hA55A);
      check("t2_parity",     got_p,    0);
      check("t2_frame",      got_f,    0);
      loop_en = 1'b0;
      idle(20);

      // Bad parity on byte 2
      base = vld_cnt;
      drive_frame(frame(8'hA5, 1'b0, 1'b1));
      drive_frame(frame(8'h5A, 1'b1, 1'b1));
      idle(20);
      check("t3_vld_pulses", vld_cnt - base, 1);
      check("t3_data",       got_data, 16'hA55A);
      check("t3_parity",     got_p,    1);
      check("t3_frame",      got_f,    0);

      // Low stop bit on byte 1, line held low 30 cycles
      base = vld_cnt;
      drive_frame(frame(8'hA5, 1'b0, 1'b0));
      rx_drv = 1'b0;
      idle(20);
      rx_drv = 1'b1;
      idle(20);
      drive_frame(frame(8'h5A, 1'b0, 1'b1));
      idle(20);
      check("t4_vld_pulses", vld_cnt - base, 1);
      check("t4_data",       got_data, 16'hA55A);
      check("t4_parity",     got_p,    0);
      check("t4_frame",      got_f,    1);

      // Glitch shorter than half a bit, then a clean word
      base = vld_cnt;
      rx_drv = 1'b0;
      idle(3);
      rx_drv = 1'b1;
      idle(40);
      check("t5_glitch_no_vld", vld_cnt - base, 0);
      drive_frame(frame(8'h12, 1'b0, 1'b1));
      drive_frame(frame(8'h34, 1'b0, 1'b1));
      idle(20);
      check("t5_vld_pulses", vld_cnt - base, 1);
      check("t5_data",       got_data, 16'h1234);
      check("t5_parity",     got_p,    0);
      check("t5_frame",      got_f,    0);

      // Reset in the middle of a word
      bus.cmd_in  = 16'hA55A;
      bus.cmd_vld = 1'b1;
      @(posedge clk); #1;
      bus.cmd_vld = 1'b0;
      idle(50);
      check("t6_tx_before_rst",  tx,          0);
      check("t6_rdy_before_rst", bus.cmd_rdy, 0);
      rst_n = 1'b0;
      #1;
      check("t6_tx_in_rst",  tx,          1);
      check("t6_rdy_in_rst", bus.cmd_rdy, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      tx_capture(16'h0F01, 1'b0, cap, low);
      check("t6_byte1_frame", cap[10:0],  frame(8'h0F, 1'b0, 1'b1));
      check("t6_byte2_frame", cap[21:11], frame(8'h01, 1'b0, 1'b1));
      check("t6_rdy_low",     low,        220);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
